// File: rtl/solver_pkg.sv
// Shared types and constants for the solver dispatch front-end.
package solver_pkg;

  localparam int ITER_BITS           = 16;
  localparam int DEF_LIMB_INDEX_BITS = 6;
  localparam int DEF_LIMB_BITS       = 32;
  localparam int DEF_ID_BITS         = 16;
  localparam int WDOG_BITS           = 24;

  localparam logic [WDOG_BITS-1:0] TIMEOUT_CYCLES = {WDOG_BITS{1'b1}};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_HDR,
    ST_LOAD_RE,
    ST_LOAD_IM,
    ST_START,
    ST_RUN,
    ST_RESULT,
    ST_DRAIN
  } dispatch_state_e;

endpackage

// File: rtl/dispatch_watchdog.sv
// Cycle counter that saturates at TIMEOUT_CYCLES; expired only while enabled.
module dispatch_watchdog
  import solver_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != TIMEOUT_CYCLES))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == TIMEOUT_CYCLES);

endmodule

// File: rtl/solver_dispatch.sv
// Job framing, limb loading and result return in front of solver_control.
// Optional RUN watchdog enabled by defining SOLVER_DISPATCH_TIMEOUT_EN.
module solver_dispatch
  import solver_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
  parameter int LIMB_BITS       = DEF_LIMB_BITS,
  parameter int ID_BITS         = DEF_ID_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic [ITER_BITS-1:0]       cfg_iter_lim,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_BITS-1:0]       in_data,
  input  logic                       in_last,
  output logic                       limb_wr_en,
  output logic                       limb_wr_imag,
  output logic [LIMB_INDEX_BITS-1:0] limb_wr_addr,
  output logic [LIMB_BITS-1:0]       limb_wr_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [ITER_BITS-1:0]       iter_lim_data,
  output logic                       start,
  input  logic                       solver_done,
  input  logic [ITER_BITS-1:0]       solver_iters,
  input  logic                       solver_diverged,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_BITS-1:0]         out_id,
  output logic [ITER_BITS-1:0]       out_iters,
  output logic                       out_diverged,
  output logic                       busy,
  output logic                       err
);

  localparam logic [LIMB_INDEX_BITS-1:0] LIMB_ONE = 1;

  dispatch_state_e            state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_d;
  logic [ITER_BITS-1:0]       iter_lim_q, iter_lim_d;
  logic [ID_BITS-1:0]         id_q, id_d;
  logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d;
  logic [ITER_BITS-1:0]       iters_q, iters_d;
  logic                       div_q, div_d;
  logic                       err_q, err_d;
  logic                       last_limb;

  assign last_limb = (cnt_q == (num_limbs_q - LIMB_ONE));

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
  logic wd_en, wd_expired;
  assign wd_en = (state_q == ST_RUN);

  dispatch_watchdog u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (!wd_en),
    .en      (wd_en),
    .expired (wd_expired)
  );
`endif

  always_comb begin
    state_d         = state_q;
    num_limbs_d     = num_limbs_q;
    iter_lim_d      = iter_lim_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    iters_d         = iters_q;
    div_d           = div_q;
    err_d           = err_q;
    cfg_ready       = 1'b0;
    in_ready        = 1'b0;
    limb_wr_en      = 1'b0;
    limb_wr_imag    = 1'b0;
    limb_wr_addr    = '0;
    limb_wr_data    = '0;
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
    num_limbs_data  = '0;
    iter_lim_data   = '0;
    start           = 1'b0;
    out_valid       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          num_limbs_d = (cfg_num_limbs == '0) ? LIMB_ONE : cfg_num_limbs;
          iter_lim_d  = cfg_iter_lim;
          state_d     = ST_CFG;
        end else if (in_valid) begin
          state_d = ST_HDR;
        end
      end
      ST_CFG: begin
        wr_num_limbs_en = 1'b1;
        wr_iter_lim_en  = 1'b1;
        num_limbs_data  = num_limbs_q;
        iter_lim_data   = iter_lim_q;
        state_d         = ST_HDR;
      end
      ST_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last) begin
            err_d = 1'b1;
          end else begin
            id_d    = in_data[ID_BITS-1:0];
            cnt_d   = '0;
            state_d = ST_LOAD_RE;
          end
        end else if (cfg_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_RE, ST_LOAD_IM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          limb_wr_en   = 1'b1;
          limb_wr_imag = (state_q == ST_LOAD_IM);
          limb_wr_addr = cnt_q;
          limb_wr_data = in_data;
          // Framing is only legal when in_last lands on the final imag limb.
          if (state_q == ST_LOAD_RE) begin
            if (in_last) begin
              err_d   = 1'b1;
              state_d = ST_HDR;
            end else if (last_limb) begin
              cnt_d   = '0;
              state_d = ST_LOAD_IM;
            end else begin
              cnt_d = cnt_q + LIMB_ONE;
            end
          end else if (last_limb) begin
            if (in_last) begin
              state_d = ST_START;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = ST_HDR;
          end else begin
            cnt_d = cnt_q + LIMB_ONE;
          end
        end
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = ST_HDR;
      end
      ST_START: begin
        start   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (solver_done) begin
          iters_d = solver_iters;
          div_d   = solver_diverged;
          state_d = ST_RESULT;
        end
`ifdef SOLVER_DISPATCH_TIMEOUT_EN
        else if (wd_expired) begin
          iters_d = {ITER_BITS{1'b1}};
          div_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESULT;
        end
`endif
      end
      ST_RESULT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_HDR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_limbs_q <= LIMB_ONE;
      iter_lim_q  <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      iters_q     <= '0;
      div_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_limbs_q <= num_limbs_d;
      iter_lim_q  <= iter_lim_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      iters_q     <= iters_d;
      div_q       <= div_d;
      err_q       <= err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HDR);
  assign err          = err_q;
  assign out_id       = id_q;
  assign out_iters    = iters_q;
  assign out_diverged = div_q;

endmodule
